// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD conversion sequencer: segment patterns,
// FSM state encoding and the scratch-digit sizing helper.
package bcd_pkg;

    // FSM states of the converter
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Active-low seven-segment patterns, segment a in the MSB (a..g)
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    // Scratch BCD digits needed for a WIDTH-bit value (worst-case bound)
    function automatic int calc_sd(input int width);
        return (width + 2) / 3 + 1;
    endfunction

endpackage

// File: rtl/bcd_seg7_decoder.sv
// One BCD digit to active-low seven-segment pattern, with forced blanking.
module bcd_seg7_decoder
    import bcd_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    // Table lookup; non-decimal codes and forced blank show nothing
    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_bcd)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_conversion_sequencer.sv
// Sequential double-dabble binary-to-BCD converter driving HEX displays.
// Handshake: a trigger (start, or auto_en with a changed binary) is only
// accepted in IDLE; busy is high for exactly WIDTH cycles, then done pulses
// for one cycle with bcd/overflow/hex already showing the new result.
// Nothing presented while busy is queued.
module bcd_conversion_sequencer
    import bcd_pkg::*;
#(
    parameter int WIDTH    = 6,
    parameter int DIGITS   = 2,
    parameter int BLANK_LZ = 0
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      binary,
    input  logic                  start,
    input  logic                  auto_en,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   hex,
    output state_t                dbg_state
);

    localparam int         SD       = calc_sd(WIDTH);
    localparam logic [4:0] CNT_LOAD = 5'(WIDTH);

    state_t                r_state;
    state_t                w_next_state;
    logic [WIDTH-1:0]      r_shift;
    logic [WIDTH-1:0]      r_loaded;
    logic [WIDTH-1:0]      r_last;
    logic [4*SD-1:0]       r_scratch;
    logic [4:0]            r_cnt;
    logic [4*DIGITS-1:0]   r_bcd;
    logic                  r_ovf;

    logic                  w_trigger;
    logic [4*SD-1:0]       w_adj;
    logic [4*SD-1:0]       w_scratch_nxt;
    logic [4*DIGITS-1:0]   w_bcd_nxt;
    logic                  w_ovf_nxt;
    logic [DIGITS-1:0]     w_blank;
    logic [7*DIGITS-1:0]   w_seg;

    assign w_trigger = start || (auto_en && (binary != r_last));

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_trigger) w_next_state = ST_SHIFT;
            ST_SHIFT: if (r_cnt == 5'd1) w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Add-3 correction on every scratch digit that is 5 or more
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < SD; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
        end
    end

    assign w_scratch_nxt = {w_adj[4*SD-2:0], r_shift[WIDTH-1]};

    // Low DIGITS digits of the final scratch, zero-padded if the scratch is narrower
    for (genvar g = 0; g < DIGITS; g++) begin : g_bcd_nxt
        if (g < SD) begin : g_from_scratch
            assign w_bcd_nxt[4*g +: 4] = w_scratch_nxt[4*g +: 4];
        end else begin : g_pad
            assign w_bcd_nxt[4*g +: 4] = 4'd0;
        end
    end

    // Overflow: any scratch digit beyond the displayed ones is nonzero; a carry
    // out of the scratch cannot happen for this sizing but is folded in anyway
    always_comb begin
        w_ovf_nxt = w_adj[4*SD-1];
        for (int i = DIGITS; i < SD; i++) begin
            if (w_scratch_nxt[4*i +: 4] != 4'd0) w_ovf_nxt = 1'b1;
        end
    end

    // Datapath: load on trigger, shift in SHIFT, commit on the final shift so
    // the result is already visible during the DONE cycle
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_shift   <= '0;
            r_loaded  <= '0;
            r_last    <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_shift   <= binary;
                        r_loaded  <= binary;
                        r_scratch <= '0;
                        r_cnt     <= CNT_LOAD;
                    end
                end
                ST_SHIFT: begin
                    r_shift   <= r_shift << 1;
                    r_scratch <= w_scratch_nxt;
                    r_cnt     <= r_cnt - 5'd1;
                    if (r_cnt == 5'd1) begin
                        r_bcd  <= w_bcd_nxt;
                        r_ovf  <= w_ovf_nxt;
                        r_last <= r_loaded;
                    end
                end
                default: ;
            endcase
        end
    end

    // Leading-zero blanking, scanning from the most significant digit down
    always_comb begin
        logic v_zero_run;
        v_zero_run = 1'b1;
        w_blank    = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            v_zero_run = v_zero_run && (r_bcd[4*k +: 4] == 4'd0);
            w_blank[k] = (BLANK_LZ != 0) && (k > 0) && v_zero_run && !r_ovf;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_seg7_decoder u_dec (
            .i_bcd   (r_bcd[4*g +: 4]),
            .i_blank (w_blank[g]),
            .o_seg   (w_seg[7*g +: 7])
        );
        assign hex[7*g +: 7] = r_ovf ? SEG_DASH : w_seg[7*g +: 7];
    end

    assign busy      = (r_state == ST_SHIFT);
    assign done      = (r_state == ST_DONE);
    assign overflow  = r_ovf;
    assign bcd       = r_bcd;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_bcd_conversion_sequencer.sv
// Bench for bcd_conversion_sequencer: directed scenarios plus random traffic,
// checked every cycle against a transaction-level arithmetic model.
module tb_bcd_conversion_sequencer;

    localparam int WIDTH    = 7;
    localparam int DIGITS   = 2;
    localparam int BLANK_LZ = 1;

    logic                 clk;
    logic                 reset;
    logic [WIDTH-1:0]     binary;
    logic                 start;
    logic                 auto_en;
    logic                 busy;
    logic                 done;
    logic                 overflow;
    logic [4*DIGITS-1:0]  bcd;
    logic [7*DIGITS-1:0]  hex;
    bcd_pkg::state_t      dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    bcd_conversion_sequencer #(
        .WIDTH    (WIDTH),
        .DIGITS   (DIGITS),
        .BLANK_LZ (BLANK_LZ)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .binary    (binary),
        .start     (start),
        .auto_en   (auto_en),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .bcd       (bcd),
        .hex       (hex),
        .dbg_state (dbg_state)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    // m_phase: 0 idle, 1 converting, 2 result cycle
    int                  m_phase  = 0;
    int                  m_left   = 0;
    int                  m_val    = 0;
    int                  m_last   = 0;
    logic [4*DIGITS-1:0] m_bcd    = '0;
    logic                m_ovf    = 1'b0;
    bit                  m_valid  = 1'b0;

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int p;
        int t;
        r = '0;
        p = 1;
        for (int k = 0; k < DIGITS; k++) p = p * 10;
        t = v % p;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0000001;
            4'd1: return 7'b1001111;
            4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;
            4'd4: return 7'b1001100;
            4'd5: return 7'b0100100;
            4'd6: return 7'b0100000;
            4'd7: return 7'b0001111;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [7*DIGITS-1:0] model_hex(input logic [4*DIGITS-1:0] b, input logic ovf);
        logic [7*DIGITS-1:0] h;
        bit all_zero;
        h = '0;
        for (int k = 0; k < DIGITS; k++) begin
            all_zero = 1'b1;
            for (int j = k; j < DIGITS; j++) if (b[4*j +: 4] != 4'd0) all_zero = 1'b0;
            if (ovf) h[7*k +: 7] = 7'b1111110;
            else if (BLANK_LZ != 0 && k > 0 && all_zero) h[7*k +: 7] = 7'b1111111;
            else h[7*k +: 7] = seg_of(b[4*k +: 4]);
        end
        return h;
    endfunction

    function automatic int limit();
        int p;
        p = 1;
        for (int k = 0; k < DIGITS; k++) p = p * 10;
        return p;
    endfunction

    // Model advances on the same edge as the DUT, from the same sampled inputs
    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0;
            m_left  = 0;
            m_last  = 0;
            m_bcd   = '0;
            m_ovf   = 1'b0;
            m_valid = 1'b1;
        end else begin
            case (m_phase)
                0: if (start || (auto_en && int'(binary) != m_last)) begin
                    m_val   = int'(binary);
                    m_left  = WIDTH;
                    m_phase = 1;
                end
                1: begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_phase = 2;
                        m_bcd   = to_bcd(m_val);
                        m_ovf   = (m_val >= limit());
                        m_last  = m_val;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare, away from the active edge
    always @(negedge clk) begin
        if (m_valid) begin
            check("busy",     32'(busy),     32'(m_phase == 1));
            check("done",     32'(done),     32'(m_phase == 2));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("bcd",      32'(bcd),      32'(m_bcd));
            check("hex",      32'(hex),      32'(model_hex(m_bcd, m_ovf)));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int value);
        binary = WIDTH'(value);
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < WIDTH + 10; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: no done pulse within %0d cycles", name, WIDTH + 10);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        reset   = 1'b1;
        binary  = '0;
        start   = 1'b0;
        auto_en = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state, leading digit blanked
        check("rst_bcd",  32'(bcd),  32'h0);
        check("rst_hex",  32'(hex),  32'({7'b1111111, 7'b0000001}));
        check("rst_busy", 32'(busy), 32'h0);

        // 63 via start: busy for WIDTH cycles, then done
        pulse_start(63);
        cnt = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (busy === 1'b1) cnt++;
            tick();
        end
        check("lat_busy_cycles", 32'(cnt), 32'(WIDTH));
        check("lat_done_now",    32'(done), 32'h1);
        check("d63_bcd", 32'(bcd), 32'h63);
        check("d63_hex", 32'(hex), 32'({7'b0100000, 7'b0000110}));
        check("d63_ovf", 32'(overflow), 32'h0);

        // Auto mode self-trigger, hold, retrigger
        binary  = 7'd59;
        auto_en = 1'b1;
        tick();
        wait_done("auto59");
        check("auto59_bcd", 32'(bcd), 32'h59);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (done === 1'b1) cnt++;
        end
        check("auto_hold_dones", 32'(cnt), 32'h0);
        binary = 7'd10;
        tick();
        wait_done("auto10");
        check("auto10_bcd", 32'(bcd), 32'h10);
        check("auto10_hex", 32'(hex), 32'({7'b1001111, 7'b0000001}));
        auto_en = 1'b0;
        tick();
        tick();

        // Start ignored while busy, nothing queued
        pulse_start(42);
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            binary = 7'd7;
            start  = (i >= 2 && i <= 4);
            tick();
            if (done === 1'b1) cnt++;
        end
        start = 1'b0;
        check("busy_ign_dones", 32'(cnt), 32'h1);
        check("busy_ign_bcd",   32'(bcd), 32'h42);

        // Reset mid-conversion discards the result
        pulse_start(55);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_bcd",  32'(bcd),  32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done === 1'b1) cnt++;
        end
        check("midrst_dones", 32'(cnt), 32'h0);
        pulse_start(55);
        wait_done("after_rst55");
        check("after_rst55_bcd", 32'(bcd), 32'h55);
        tick();

        // Overflow and recovery
        pulse_start(127);
        wait_done("ovf127");
        check("ovf127_flag", 32'(overflow), 32'h1);
        check("ovf127_bcd",  32'(bcd), 32'h27);
        check("ovf127_hex",  32'(hex), 32'({7'b1111110, 7'b1111110}));
        tick();
        pulse_start(99);
        wait_done("v99");
        check("v99_flag", 32'(overflow), 32'h0);
        check("v99_bcd",  32'(bcd), 32'h99);
        tick();

        // Single digit: upper digit blanked
        pulse_start(5);
        wait_done("v5");
        check("v5_hex", 32'(hex), 32'({7'b1111111, 7'b0100100}));
        tick();

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            binary  = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            start   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) auto_en = ~auto_en;
            reset   = ($urandom_range(0, 60) == 0);
            tick();
        end
        reset   = 1'b0;
        start   = 1'b0;
        auto_en = 1'b0;
        for (int i = 0; i < WIDTH + 4; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
